// File: rtl/bist_controller_gen.sv
// bist_controller_gen: parametrised multi-phase BIST sequencer with abort and restart
module bist_controller_gen #(
    parameter int CNT_W       = 10,
    parameter int N_VECTORS   = 8,
    parameter int PH_W        = 2,
    parameter int N_PHASES    = 2,
    parameter int INIT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    output logic             init,
    output logic             running,
    output logic             toggle,
    output logic             finish,
    output logic             bist_end,
    output logic             busy,
    output logic [PH_W-1:0]  phase,
    output logic [CNT_W-1:0] vec_cnt
);
    localparam int IW = INIT_CYCLES > 1 ? $clog2(INIT_CYCLES) : 1;
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_INIT = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_TOG  = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;
    localparam logic [2:0] S_END  = 3'd5;
    logic [2:0]    state;
    logic [IW-1:0] icnt;
    logic          vec_last;
    logic          phase_last;
    // outputs are a pure decode of the state register
    always_comb begin
        init       = state == S_INIT;
        running    = state == S_RUN;
        toggle     = state == S_TOG;
        finish     = state == S_FIN;
        bist_end   = state == S_END;
        busy       = init | running | toggle | finish;
        vec_last   = vec_cnt == CNT_W'(N_VECTORS - 1);
        phase_last = phase == PH_W'(N_PHASES - 1);
    end
    // sequencing; abort during a session drops straight back to idle with counters cleared
    always_ff @(posedge clk) begin
        if (reset || (abort && busy)) begin
            state   <= S_IDLE;
            icnt    <= '0;
            phase   <= '0;
            vec_cnt <= '0;
        end else begin
            case (state)
                S_IDLE, S_END: if (start) begin
                    state   <= S_INIT;
                    icnt    <= '0;
                    phase   <= '0;
                    vec_cnt <= '0;
                end
                S_INIT: if (icnt == IW'(INIT_CYCLES - 1)) state <= S_RUN;
                        else icnt <= icnt + 1'b1;
                S_RUN:  if (vec_last) state <= phase_last ? S_FIN : S_TOG;
                        else vec_cnt <= vec_cnt + 1'b1;
                S_TOG: begin
                    state   <= S_RUN;
                    phase   <= phase + 1'b1;
                    vec_cnt <= '0;
                end
                S_FIN:   state <= S_END;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
